// File: rtl/uart_tx_engine_pkg.sv
// uart_tx_engine_pkg: parity encodings and FSM states shared by the UART transmitter
package uart_tx_engine_pkg;
   localparam int UART_CHECK_NONE = 0;
   localparam int UART_CHECK_ODD  = 1;
   localparam int UART_CHECK_EVEN = 2;
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_e;
endpackage

// File: rtl/uart_tx_engine_baud_tick.sv
// uart_baud_tick: bit-period counter running 0..P_DIV-1 with a tick on the final count
//   clock, reset : system clock, synchronous active-high reset
//   i_clear      : holds the counter at 0
//   o_tick       : high while the count equals P_DIV-1 (last cycle of a bit)
module uart_baud_tick #(
   parameter int P_DIV = 10
) (
   input  logic clock,
   input  logic reset,
   input  logic i_clear,
   output logic o_tick
);
   localparam int CW = (P_DIV > 1) ? $clog2(P_DIV) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      o_tick = (cnt_q == CW'(P_DIV - 1));
      cnt_d  = (i_clear || o_tick) ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: single-clock UART transmitter with a one-entry holding buffer
//   clock, reset     : system clock, synchronous active-high reset
//   i_user_tx_data   : byte to send, captured when valid && ready
//   i_user_tx_valid  : byte valid
//   o_user_tx_ready  : holding buffer empty
//   o_uart_tx        : registered serial line, idle high
//   o_tx_busy        : frame in progress or buffer occupied
//   o_tx_done        : pulse on the last clock of the final stop bit
module uart_tx_engine
   import uart_tx_engine_pkg::*;
#(
   parameter int P_SYSTEM_CLK      = 50_000_000,
   parameter int P_UART_BUADRATE   = 115200,
   parameter int P_UART_DATA_WIDTH = 8,
   parameter int P_UART_STOP_WIDTH = 1,
   parameter int P_UART_CHECK      = 0
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
   input  logic                         i_user_tx_valid,
   output logic                         o_user_tx_ready,
   output logic                         o_uart_tx,
   output logic                         o_tx_busy,
   output logic                         o_tx_done
);
   localparam int N = P_SYSTEM_CLK / P_UART_BUADRATE;
   localparam int W = P_UART_DATA_WIDTH;
   tx_state_e      state_q, state_d;
   logic [W-1:0]   hold_data_q, hold_data_d, shift_q, shift_d;
   logic [3:0]     bit_cnt_q, bit_cnt_d;
   logic           stop_cnt_q, stop_cnt_d;
   logic           hold_valid_q, hold_valid_d, parity_q, parity_d, tx_q, tx_d;
   logic           load, tick;
   uart_baud_tick #(.P_DIV(N)) u_baud_tick (
      .clock   (clock),
      .reset   (reset),
      .i_clear (state_q == S_IDLE),
      .o_tick  (tick)
   );
   always_comb begin
      state_d      = state_q;
      hold_data_d  = hold_data_q;
      hold_valid_d = hold_valid_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      bit_cnt_d    = bit_cnt_q;
      stop_cnt_d   = stop_cnt_q;
      load         = 1'b0;
      o_tx_done    = 1'b0;
      if (i_user_tx_valid && !hold_valid_q) begin
         hold_valid_d = 1'b1;
         hold_data_d  = i_user_tx_data;
      end
      case (state_q)
         S_IDLE:   load = hold_valid_q;
         S_START:  state_d = tick ? S_DATA : S_START;
         S_DATA:
            if (tick) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'(W - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = (P_UART_CHECK != UART_CHECK_NONE) ? S_PARITY : S_STOP;
               end
            end
         S_PARITY: state_d = tick ? S_STOP : S_PARITY;
         S_STOP:
            if (tick) begin
               stop_cnt_d = stop_cnt_q + 1'b1;
               if (stop_cnt_q == 1'(P_UART_STOP_WIDTH - 1)) begin
                  stop_cnt_d = 1'b0;
                  o_tx_done  = 1'b1;
                  load       = hold_valid_q;
                  state_d    = S_IDLE;
               end
            end
         default:  state_d = S_IDLE;
      endcase
      // Load cannot coincide with a capture: it needs a full buffer, capture needs an empty one.
      if (load) begin
         state_d      = S_START;
         shift_d      = hold_data_q;
         parity_d     = (P_UART_CHECK == UART_CHECK_EVEN) ? ^hold_data_q : ~^hold_data_q;
         hold_valid_d = 1'b0;
      end
      // Line is registered, so it is driven from the next-state view of the frame.
      tx_d = (state_d == S_START)  ? 1'b0 :
             (state_d == S_DATA)   ? shift_d[0] :
             (state_d == S_PARITY) ? parity_d : 1'b1;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         hold_data_q  <= '0;
         hold_valid_q <= 1'b0;
         shift_q      <= '0;
         parity_q     <= 1'b0;
         bit_cnt_q    <= '0;
         stop_cnt_q   <= 1'b0;
         tx_q         <= 1'b1;
      end else begin
         state_q      <= state_d;
         hold_data_q  <= hold_data_d;
         hold_valid_q <= hold_valid_d;
         shift_q      <= shift_d;
         parity_q     <= parity_d;
         bit_cnt_q    <= bit_cnt_d;
         stop_cnt_q   <= stop_cnt_d;
         tx_q         <= tx_d;
      end
   end
   assign o_uart_tx       = tx_q;
   assign o_user_tx_ready = !hold_valid_q;
   assign o_tx_busy       = (state_q != S_IDLE) || hold_valid_q;
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed frame checks on four transmitter configurations (N = 10)
module tb_uart_tx_engine;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] valid = '0;
   logic [7:0] data [4];
   logic [3:0] ready, tx, busy, done;
   logic       rdy_m0, rdy_m1, rdy_m2;
   int         checks = 0;
   int         errors = 0;
   typedef struct {int d; logic [7:0] b; logic [31:0] exp; int nslots;} vec_t;
   vec_t vt [7];
   always #5 clock = ~clock;
   uart_tx_engine #(.P_SYSTEM_CLK(1_000_000), .P_UART_BUADRATE(100_000), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) u_none (
      .clock(clock), .reset(reset), .i_user_tx_data(data[0]), .i_user_tx_valid(valid[0]),
      .o_user_tx_ready(ready[0]), .o_uart_tx(tx[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]));
   uart_tx_engine #(.P_SYSTEM_CLK(1_000_000), .P_UART_BUADRATE(100_000), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(2)) u_even (
      .clock(clock), .reset(reset), .i_user_tx_data(data[1]), .i_user_tx_valid(valid[1]),
      .o_user_tx_ready(ready[1]), .o_uart_tx(tx[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1]));
   uart_tx_engine #(.P_SYSTEM_CLK(1_000_000), .P_UART_BUADRATE(100_000), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(1)) u_odd (
      .clock(clock), .reset(reset), .i_user_tx_data(data[2]), .i_user_tx_valid(valid[2]),
      .o_user_tx_ready(ready[2]), .o_uart_tx(tx[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2]));
   uart_tx_engine #(.P_SYSTEM_CLK(1_000_000), .P_UART_BUADRATE(100_000), .P_UART_STOP_WIDTH(2), .P_UART_CHECK(0)) u_stop2 (
      .clock(clock), .reset(reset), .i_user_tx_data(data[3]), .i_user_tx_valid(valid[3]),
      .o_user_tx_ready(ready[3]), .o_uart_tx(tx[3]), .o_tx_busy(busy[3]), .o_tx_done(done[3]));
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask
   // Offers byte b and returns #1 after the handshake edge k.
   task automatic send(input int d, input logic [7:0] b, input bit keep);
      int n;
      n = 0;
      @(negedge clock);
      valid[d] = 1'b1;
      data[d]  = b;
      while (!ready[d] && n < 500) begin
         @(negedge clock);
         n++;
      end
      check($sformatf("dut%0d ready before send", d), 32'(ready[d]), 32'd1);
      @(posedge clock);
      #1;
      if (!keep) valid[d] = 1'b0;
   endtask
   // Called #1 after handshake edge k; step m samples the cycle following edge k+m.
   task automatic watch(input int d, input logic [31:0] exp, input int nslots, input int ndone, input string name);
      int nd, last, len;
      nd = 0;
      last = -1;
      len = nslots * 10;
      for (int m = 0; m <= len + 1; m++) begin
         @(negedge clock);
         if (m == 0) begin
            check({name, " line before start"}, 32'(tx[d]), 32'd1);
            rdy_m0 = ready[d];
         end
         if (m == 1) rdy_m1 = ready[d];
         if (m == 2) rdy_m2 = ready[d];
         if (m >= 1 && m <= len && (m - 1) % 10 == 4)
            check($sformatf("%s slot%0d", name, (m - 1) / 10), 32'(tx[d]), 32'(exp[(m - 1) / 10]));
         if (done[d]) begin
            nd++;
            last = m;
         end
         if (m == len) check({name, " busy last stop"}, 32'(busy[d]), 32'd1);
         if (m == len + 1) check({name, " busy after frame"}, 32'(busy[d]), 32'd0);
      end
      check({name, " done count"}, nd, ndone);
      check({name, " done cycle"}, last, len);
   endtask
   initial begin
      int bad_tx, bad_done, bad_busy;
      for (int i = 0; i < 4; i++) data[i] = 8'h00;
      vt[0] = '{0, 8'hA5, 32'b1101001010, 10};
      vt[1] = '{1, 8'h07, 32'b11000001110, 11};
      vt[2] = '{2, 8'h07, 32'b10000001110, 11};
      vt[3] = '{3, 8'h00, 32'b11000000000, 11};
      vt[4] = '{0, 8'h3C, 32'b1001111000, 10};
      vt[5] = '{1, 8'h00, 32'b10000000000, 11};
      vt[6] = '{2, 8'h80, 32'b10100000000, 11};
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("reset tx", 32'(tx), 32'hF);
      check("reset ready", 32'(ready), 32'hF);
      check("reset busy", 32'(busy), 32'h0);
      check("reset done", 32'(done), 32'h0);
      for (int i = 0; i < 7; i++) begin
         send(vt[i].d, vt[i].b, 1'b0);
         watch(vt[i].d, vt[i].exp, vt[i].nslots, 1, $sformatf("row%0d", i));
         check($sformatf("row%0d ready while loading", i), 32'(rdy_m0), 32'd0);
         check($sformatf("row%0d ready after load", i), 32'(rdy_m1), 32'd1);
      end
      // Back-to-back 55 then AA with valid held: AA accepted at edge k+2, zero gap.
      send(0, 8'h55, 1'b1);
      data[0] = 8'hAA;
      fork
         watch(0, {12'b0, 10'b1101010100, 10'b1010101010}, 20, 2, "b2b");
         begin
            repeat (3) @(negedge clock);
            valid[0] = 1'b0;
         end
      join
      check("b2b ready while loading", 32'(rdy_m0), 32'd0);
      check("b2b ready after load", 32'(rdy_m1), 32'd1);
      check("b2b second accepted", 32'(rdy_m2), 32'd0);
      // Buffer full while valid waits with changing data: only 44 (present at the ready edge) goes out.
      send(0, 8'h0F, 1'b1);
      data[0] = 8'h33;
      fork
         watch(0, {2'b0, 10'b1010001000, 10'b1001100110, 10'b1000011110}, 30, 3, "hold");
         begin
            repeat (3) @(negedge clock);
            data[0] = 8'h11;
            repeat (28) @(negedge clock);
            data[0] = 8'h22;
            repeat (30) @(negedge clock);
            data[0] = 8'h44;
            repeat (43) @(negedge clock);
            valid[0] = 1'b0;
         end
      join
      // Reset at clock 45 of a frame with the buffer full.
      send(0, 8'hC3, 1'b1);
      data[0] = 8'h5A;
      repeat (3) @(negedge clock);
      valid[0] = 1'b0;
      check("rst buffer full", 32'(ready[0]), 32'd0);
      bad_done = 0;
      repeat (42) begin
         @(negedge clock);
         if (done[0]) bad_done++;
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("rst line", 32'(tx[0]), 32'd1);
      check("rst ready", 32'(ready[0]), 32'd1);
      check("rst busy", 32'(busy[0]), 32'd0);
      bad_tx = 0;
      bad_busy = 0;
      repeat (150) begin
         @(negedge clock);
         if (tx[0] !== 1'b1) bad_tx++;
         if (done[0]) bad_done++;
         if (busy[0] !== 1'b0) bad_busy++;
      end
      check("rst no frame after", bad_tx, 0);
      check("rst no done", bad_done, 0);
      check("rst stays idle", bad_busy, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
